mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Memory-access stage directly downstream of the ALU. It consumes the ALU's `completed`/`result` (the effective address for loads/stores, the final value otherwise) together with the decoded instruction and register pair. It performs lb/lh/lw/lbu/lhu/sb/sh/sw over a single-outstanding req/ack data bus and returns a writeback value to the core. AMO, CSR and fence handling remain in core.

Parameters:
TIMEOUT_CYCLES, 0, bus-wait limit in cycles; 0 disables the watchdog.

Ports:
clk  input  1  clock, rising edge
rstn  input  1  synchronous, active-high reset (1 = reset)
enabled  input  1  one-cycle start pulse (ALU completed)
instr  input  instructions  decoded instruction, held stable by core until completed
register  input  regvpair  operands; rs2 supplies store data
alu_result  input  32  effective address, or passthrough value
mem_req  output  1  bus request
mem_we  output  1  1 = write
mem_addr  output  32  word-aligned address ({alu_result[31:2],2'b00})
mem_wstrb  output  4  byte-lane write enables
mem_wdata  output  32  lane-replicated store data
mem_rdata  input  32  read data, valid when mem_ack=1
mem_ack  input  1  bus completion, one cycle
completed  output  1  one-cycle done pulse
result  output  32  writeback value, valid when completed=1
misaligned  output  1  with completed: address misaligned
access_fault  output  1  with completed: watchdog expired

Behaviour:
- Reset (rstn=1 at a clock edge): state=IDLE. mem_req, mem_we, completed, misaligned and access_fault are 0. mem_wstrb=0; mem_addr, mem_wdata and result are 0; the wait counter is 0. Reset mid-transaction drops mem_req on the next edge, and any later mem_ack is ignored.
- States: IDLE, BUS, DONE-free design. The completed pulse is issued from the transition edge itself.
- IDLE with enabled=1, non-memory instr: next edge completed=1 and result=alu_result. Latency is 1.
- IDLE with enabled=1, memory instr, misaligned address: next edge completed=1, misaligned=1, result=0, and no bus cycle is issued.
  - Misaligned means lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]≠0.
- IDLE with enabled=1, aligned memory instr: next edge state=BUS and mem_req=1. mem_addr, mem_we, mem_wstrb, mem_wdata and the low address bits are latched.
- Store lanes and data:
  - sb: wstrb=4'b0001<<a[1:0], wdata={4{rs2[7:0]}}.
  - sh: wstrb=4'b0011<<{a[1],1'b0}, wdata={2{rs2[15:0]}}.
  - sw: wstrb=4'b1111, wdata=rs2.
  - Loads: wstrb=0, mem_we=0.
- BUS: request fields are held stable until mem_ack is sampled. mem_ack may arrive on the first BUS cycle (zero wait).
  - On the ack edge: mem_req=0, state=IDLE, completed=1.
  - Load result: lane = rdata>>(8*a[1:0]). lb/lh sign-extend lane[7:0]/[15:0]; lbu/lhu zero-extend; lw returns rdata.
  - Store result: 0.
- Watchdog: the counter increments each BUS cycle without ack. With TIMEOUT_CYCLES>0 and count reaching TIMEOUT_CYCLES-1 without ack, the next edge gives completed=1, access_fault=1, mem_req=0 and result=0, and the state returns to IDLE.
- completed, misaligned and access_fault are one-cycle pulses and otherwise 0.
- enabled while in BUS is ignored. mem_ack while mem_req=0 is ignored.
- Back-to-back: a new enabled is accepted in the cycle completed is high (state already IDLE).

Decomposition:
- The shared package (def.sv) holds the instructions/regvpair typedefs and a mem_state enum, plus the constants WSTRB_B=4'b0001, WSTRB_H=4'b0011 and WSTRB_W=4'b1111.
- One natural sub-module: load_extender, a combinational block taking rdata, addr[1:0] and the lb/lh/lw/lbu/lhu flags and producing the 32-bit extended value. It is reusable by core for AMO read data.

Test Plan:
- addi passthrough: enabled=1 with alu_result=32'h0000_1234 → next cycle completed=1 with result 32'h1234; mem_req never rises.
- lb, sign extension on lane 3: lb at addr 32'h100F, rdata=32'h80FF_FFFF, zero-wait ack → mem_addr=32'h100C, then result=32'hFFFF_FF80. The same access with lbu gives 32'h0000_0080.
- sh on the upper half: sh at addr 32'h2002, rs2=32'hDEAD_BEEF → mem_we=1, wstrb=4'b1100, wdata=32'hBEEF_BEEF. With ack after 3 wait cycles, completed=1 and result=0.
- Misaligned lw: lw at addr 32'h3001 → completed=1 with misaligned=1 one cycle after enabled; mem_req stays 0 throughout.
- Timeout: TIMEOUT_CYCLES=8, lw at 32'h4000, ack never asserted → completed=1 and access_fault=1 after 8 BUS cycles; mem_req then returns to 0.
- Reset mid-transaction: assert rstn during BUS, then pulse mem_ack two cycles later → mem_req=0 after the reset edge; completed stays 0; the next lw at 32'h5000 with rdata=32'h1234_5678 completes normally.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the load/store stage.
// Also used by the core when it reuses load_extender for AMO read data.
package mem_access_unit_pkg;

    typedef struct packed {
        logic lb;
        logic lh;
        logic lw;
        logic lbu;
        logic lhu;
        logic sb;
        logic sh;
        logic sw;
    } instructions;

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
    } regvpair;

    typedef enum logic {
        MS_IDLE = 1'b0,
        MS_BUS  = 1'b1
    } mem_state;

    localparam logic [3:0] WSTRB_B = 4'b0001;
    localparam logic [3:0] WSTRB_H = 4'b0011;
    localparam logic [3:0] WSTRB_W = 4'b1111;

    function automatic logic is_load(input instructions i);
        return i.lb | i.lh | i.lw | i.lbu | i.lhu;
    endfunction

    function automatic logic is_store(input instructions i);
        return i.sb | i.sh | i.sw;
    endfunction

    function automatic logic is_misaligned(input instructions i, input logic [1:0] a);
        return ((i.lh | i.lhu | i.sh) & a[0]) | ((i.lw | i.sw) & (a != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Single-outstanding req/ack data bus between the memory stage and memory.
interface mem_access_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_access_unit_load_extender.sv
// Picks the addressed lane out of a read word and sign/zero-extends it.
module load_extender
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        lb_i,
    input  logic        lh_i,
    input  logic        lw_i,
    input  logic        lbu_i,
    input  logic        lhu_i,
    output logic [31:0] value_o
);

    logic [31:0] lane;

    always_comb begin
        lane    = rdata_i >> {addr_lo_i, 3'b000};
        value_o = '0;
        if (lb_i) begin
            value_o = {{24{lane[7]}}, lane[7:0]};
        end else if (lh_i) begin
            value_o = {{16{lane[15]}}, lane[15:0]};
        end else if (lbu_i) begin
            value_o = {24'b0, lane[7:0]};
        end else if (lhu_i) begin
            value_o = {16'b0, lane[15:0]};
        end else if (lw_i) begin
            value_o = rdata_i;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage after the ALU: passes non-memory results through, otherwise
// runs one bus access and returns the extended load value (or 0 for stores).
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0
)
(
    input  logic                clk,
    input  logic                rstn,
    input  logic                enabled_i,
    input  instructions         instr_i,
    input  regvpair             register_i,
    input  logic [31:0]         alu_result_i,
    mem_access_unit_if.master   bus,
    output logic                completed_o,
    output logic [31:0]         result_o,
    output logic                misaligned_o,
    output logic                access_fault_o
);

    localparam bit          WD_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [31:0] WD_LAST = WD_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    mem_state    state_q;
    instructions instr_q;
    logic        req_q, we_q, completed_q, misaligned_q, fault_q;
    logic [31:0] addr_q, wdata_q, result_q, cnt_q;
    logic [3:0]  wstrb_q;
    logic [1:0]  addr_lo_q;
    logic [3:0]  wstrb_d;
    logic [31:0] wdata_d;
    logic [31:0] ext_value;
    logic        unused_rs1;

    assign unused_rs1 = ^register_i.rs1;

    always_comb begin
        wstrb_d = '0;
        wdata_d = '0;
        if (instr_i.sb) begin
            wstrb_d = WSTRB_B << alu_result_i[1:0];
            wdata_d = {4{register_i.rs2[7:0]}};
        end else if (instr_i.sh) begin
            wstrb_d = WSTRB_H << {alu_result_i[1], 1'b0};
            wdata_d = {2{register_i.rs2[15:0]}};
        end else if (instr_i.sw) begin
            wstrb_d = WSTRB_W;
            wdata_d = register_i.rs2;
        end
    end

    load_extender u_ext (
        .rdata_i   (bus.mem_rdata),
        .addr_lo_i (addr_lo_q),
        .lb_i      (instr_q.lb),
        .lh_i      (instr_q.lh),
        .lw_i      (instr_q.lw),
        .lbu_i     (instr_q.lbu),
        .lhu_i     (instr_q.lhu),
        .value_o   (ext_value)
    );

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q      <= MS_IDLE;
            instr_q      <= '0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wstrb_q      <= '0;
            wdata_q      <= '0;
            addr_lo_q    <= '0;
            cnt_q        <= '0;
            completed_q  <= 1'b0;
            misaligned_q <= 1'b0;
            fault_q      <= 1'b0;
            result_q     <= '0;
        end else begin
            completed_q  <= 1'b0;
            misaligned_q <= 1'b0;
            fault_q      <= 1'b0;
            case (state_q)
                MS_IDLE: begin
                    if (enabled_i) begin
                        if (!(is_load(instr_i) || is_store(instr_i))) begin
                            completed_q <= 1'b1;
                            result_q    <= alu_result_i;
                        end else if (is_misaligned(instr_i, alu_result_i[1:0])) begin
                            completed_q  <= 1'b1;
                            misaligned_q <= 1'b1;
                            result_q     <= '0;
                        end else begin
                            state_q   <= MS_BUS;
                            instr_q   <= instr_i;
                            req_q     <= 1'b1;
                            we_q      <= is_store(instr_i);
                            addr_q    <= {alu_result_i[31:2], 2'b00};
                            wstrb_q   <= wstrb_d;
                            wdata_q   <= wdata_d;
                            addr_lo_q <= alu_result_i[1:0];
                            cnt_q     <= '0;
                        end
                    end
                end
                MS_BUS: begin
                    // An ack in the final watchdog cycle still completes normally.
                    if (bus.mem_ack) begin
                        state_q     <= MS_IDLE;
                        req_q       <= 1'b0;
                        we_q        <= 1'b0;
                        wstrb_q     <= '0;
                        completed_q <= 1'b1;
                        result_q    <= is_store(instr_q) ? 32'd0 : ext_value;
                    end else if (WD_EN && (cnt_q == WD_LAST)) begin
                        state_q     <= MS_IDLE;
                        req_q       <= 1'b0;
                        we_q        <= 1'b0;
                        wstrb_q     <= '0;
                        completed_q <= 1'b1;
                        fault_q     <= 1'b1;
                        result_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: state_q <= MS_IDLE;
            endcase
        end
    end

    assign bus.mem_req    = req_q;
    assign bus.mem_we     = we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wstrb  = wstrb_q;
    assign bus.mem_wdata  = wdata_q;
    assign completed_o    = completed_q;
    assign result_o       = result_q;
    assign misaligned_o   = misaligned_q;
    assign access_fault_o = fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a byte-level behavioural model.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam int TMO = 8;
    localparam int OP_ALU = 0, OP_LB = 1, OP_LH = 2, OP_LW = 3, OP_LBU = 4,
                   OP_LHU = 5, OP_SB = 6, OP_SH = 7, OP_SW = 8;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enabled;
    instructions instr;
    regvpair     regs;
    logic [31:0] alu_result;
    logic        completed, misaligned, access_fault;
    logic [31:0] result;
    int          n_checks = 0;
    int          n_errors = 0;

    mem_access_unit_if bus();

    mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .enabled_i      (enabled),
        .instr_i        (instr),
        .register_i     (regs),
        .alu_result_i   (alu_result),
        .bus            (bus.master),
        .completed_o    (completed),
        .result_o       (result),
        .misaligned_o   (misaligned),
        .access_fault_o (access_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic instructions mk_instr(input int op);
        instructions i;
        i = '0;
        case (op)
            OP_LB:   i.lb  = 1'b1;
            OP_LH:   i.lh  = 1'b1;
            OP_LW:   i.lw  = 1'b1;
            OP_LBU:  i.lbu = 1'b1;
            OP_LHU:  i.lhu = 1'b1;
            OP_SB:   i.sb  = 1'b1;
            OP_SH:   i.sh  = 1'b1;
            OP_SW:   i.sw  = 1'b1;
            default: ;
        endcase
        return i;
    endfunction

    function automatic int op_size(input int op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            default:              return 4;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input int op, input int lo, input logic [31:0] rd);
        logic [31:0] lane, b, h;
        lane = rd >> (8 * lo);
        b    = lane & 32'hFF;
        h    = lane & 32'hFFFF;
        case (op)
            OP_LB:   return (b >= 32'd128)   ? b - 32'd256   : b;
            OP_LH:   return (h >= 32'd32768) ? h - 32'd65536 : h;
            OP_LBU:  return b;
            OP_LHU:  return h;
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] exp_wstrb(input int op, input int lo);
        logic [3:0] m;
        int sz;
        m  = '0;
        sz = op_size(op);
        if (op >= OP_SB)
            for (int i = 0; i < 4; i++)
                if (i >= lo && i < lo + sz) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] exp_wdata(input int op, input logic [31:0] rs2);
        logic [31:0] w;
        int sz;
        sz = op_size(op);
        w  = '0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = rs2[8*(i % sz) +: 8];
        return w;
    endfunction

    task automatic do_op(input int op, input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [31:0] rd, input int waits);
        bit is_mem, mis, st;
        int lo;
        is_mem     = (op != OP_ALU);
        st         = (op >= OP_SB);
        lo         = int'(addr % 4);
        mis        = is_mem && ((addr % op_size(op)) != 0);
        enabled    = 1'b1;
        instr      = mk_instr(op);
        alu_result = addr;
        regs.rs1   = $urandom;
        regs.rs2   = rs2;
        step();
        enabled = 1'b0;
        if (!is_mem || mis) begin
            chk("direct_done",   32'(completed), 32'd1);
            chk("direct_mis",    32'(misaligned), 32'(mis));
            chk("direct_fault",  32'(access_fault), 32'd0);
            chk("direct_result", result, is_mem ? 32'd0 : addr);
            chk("direct_noreq",  32'(bus.mem_req), 32'd0);
            return;
        end
        chk("req_rise",    32'(bus.mem_req), 32'd1);
        chk("req_addr",    bus.mem_addr, addr & ~32'd3);
        chk("req_we",      32'(bus.mem_we), 32'(st));
        chk("req_wstrb",   32'(bus.mem_wstrb), 32'(exp_wstrb(op, lo)));
        if (st) chk("req_wdata", bus.mem_wdata, exp_wdata(op, rs2));
        chk("req_notdone", 32'(completed), 32'd0);
        if (waits >= TMO) begin
            for (int i = 1; i < TMO; i++) begin
                enabled         = 1'($urandom_range(0, 1));
                bus.mem_rdata   = $urandom;
                step();
                chk("tmo_hold",    32'(bus.mem_req), 32'd1);
                chk("tmo_notdone", 32'(completed), 32'd0);
            end
            enabled = 1'b0;
            step();
            chk("tmo_done",   32'(completed), 32'd1);
            chk("tmo_fault",  32'(access_fault), 32'd1);
            chk("tmo_mis",    32'(misaligned), 32'd0);
            chk("tmo_result", result, 32'd0);
            chk("tmo_req",    32'(bus.mem_req), 32'd0);
        end else begin
            for (int i = 0; i < waits; i++) begin
                enabled       = 1'($urandom_range(0, 1));
                bus.mem_rdata = $urandom;
                step();
                chk("wait_hold",    32'(bus.mem_req), 32'd1);
                chk("wait_addr",    bus.mem_addr, addr & ~32'd3);
                chk("wait_notdone", 32'(completed), 32'd0);
            end
            enabled       = 1'b0;
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = rd;
            step();
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom;
            chk("ack_done",   32'(completed), 32'd1);
            chk("ack_result", result, st ? 32'd0 : exp_load(op, lo, rd));
            chk("ack_req",    32'(bus.mem_req), 32'd0);
            chk("ack_fault",  32'(access_fault), 32'd0);
            chk("ack_mis",    32'(misaligned), 32'd0);
        end
    endtask

    task automatic idle_step(input bit stray_ack);
        enabled     = 1'b0;
        bus.mem_ack = stray_ack;
        step();
        bus.mem_ack = 1'b0;
        chk("idle_notdone", 32'(completed), 32'd0);
        chk("idle_noreq",   32'(bus.mem_req), 32'd0);
    endtask

    initial begin
        int op, waits;
        rstn          = 1'b1;
        enabled       = 1'b0;
        instr         = '0;
        regs          = '0;
        alu_result    = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;
        repeat (3) step();
        chk("rst_req",    32'(bus.mem_req), 32'd0);
        chk("rst_we",     32'(bus.mem_we), 32'd0);
        chk("rst_wstrb",  32'(bus.mem_wstrb), 32'd0);
        chk("rst_addr",   bus.mem_addr, 32'd0);
        chk("rst_wdata",  bus.mem_wdata, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags",  {29'd0, completed, misaligned, access_fault}, 32'd0);
        rstn = 1'b0;
        step();

        do_op(OP_ALU, 32'h0000_1234, 32'h0, 32'h0, 0);
        idle_step(1'b0);
        do_op(OP_LB,  32'h0000_100F, 32'h0, 32'h80FF_FFFF, 0);
        do_op(OP_LBU, 32'h0000_100F, 32'h0, 32'h80FF_FFFF, 0);
        do_op(OP_SH,  32'h0000_2002, 32'hDEAD_BEEF, 32'h0, 3);
        do_op(OP_LW,  32'h0000_3001, 32'h0, 32'h0, 0);
        idle_step(1'b1);
        do_op(OP_LW,  32'h0000_4000, 32'h0, 32'h0, 100);
        idle_step(1'b0);

        enabled    = 1'b1;
        instr      = mk_instr(OP_LW);
        alu_result = 32'h0000_6000;
        step();
        enabled = 1'b0;
        chk("midrst_req", 32'(bus.mem_req), 32'd1);
        rstn = 1'b1;
        step();
        rstn = 1'b0;
        chk("midrst_drop", 32'(bus.mem_req), 32'd0);
        chk("midrst_done", 32'(completed), 32'd0);
        step();
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        chk("midrst_ackign", 32'(completed), 32'd0);
        chk("midrst_noreq",  32'(bus.mem_req), 32'd0);
        do_op(OP_LW, 32'h0000_5000, 32'h0, 32'h1234_5678, 0);
        idle_step(1'b0);

        for (int n = 0; n < 200; n++) begin
            op    = $urandom_range(0, 8);
            waits = ($urandom_range(0, 15) == 0) ? 100 : $urandom_range(0, 7);
            do_op(op, $urandom, $urandom, $urandom, waits);
            if ($urandom_range(0, 1) == 1) idle_step(1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
